// File: rtl/rv32_trap_ctrl.sv
// rv32_trap_ctrl
// Machine-mode trap controller for the rv32 core. Holds the trap CSRs
// (mstatus, mie, mtvec, mepc, mcause, mtval, mip), arbitrates between
// synchronous exceptions, mret and three asynchronous interrupt lines, and
// sequences trap entry / return as IDLE -> SAVE -> REDIRECT (mret skips SAVE).
//
// Optional feature macro: RV32_TRAP_VECTORED_EN
//   defined   : mtvec[0] selects direct (0) or vectored (1) mode; interrupts
//               in vectored mode jump to base + 4*code.
//   undefined : mtvec[1:0] hardwired to 0, every trap jumps to the base.

module rv32_trap_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exc_valid_in,
  input  logic [3:0]  exc_cause_in,
  input  logic [31:0] exc_pc_in,
  input  logic [31:0] exc_tval_in,
  input  logic        mret_in,
  input  logic        irq_ext_in,
  input  logic        irq_timer_in,
  input  logic        irq_soft_in,
  input  logic        int_allowed_in,
  input  logic [31:0] int_pc_in,
  input  logic        csr_write_in,
  input  logic [11:0] csr_in,
  input  logic [31:0] csr_wdata_in,
  output logic [31:0] csr_rdata_out,
  output logic        csr_hit_out,
  output logic        stall_out,
  output logic        flush_out,
  output logic        redirect_valid_out,
  output logic [31:0] redirect_pc_out
);

  // A single flop cannot resolve metastability, so depths below 2 are raised.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [31:0] MIE_MASK    = 32'h0000_0888;
  localparam logic [31:0] MCAUSE_MASK = 32'h8000_000F;
  localparam logic [31:0] MEPC_MASK   = 32'hFFFF_FFFC;

`ifdef RV32_TRAP_VECTORED_EN
  localparam logic [31:0] MTVEC_MASK  = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] MTVEC_MASK  = 32'hFFFF_FFFC;
`endif

  localparam logic [3:0] CODE_SOFT  = 4'd3;
  localparam logic [3:0] CODE_TIMER = 4'd7;
  localparam logic [3:0] CODE_EXT   = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SAVE     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t state_q;

  logic        stall_q;
  logic        flush_q;
  logic        redir_valid_q;
  logic [31:0] redir_pc_q;

  logic        mstatus_mie_q;
  logic        mstatus_mpie_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;

  // Trap context captured in IDLE and committed to the CSRs in SAVE.
  logic [31:0] trap_cause_q;
  logic [31:0] trap_pc_q;
  logic [31:0] trap_tval_q;

  logic [STAGES-1:0] ext_sync_q;
  logic [STAGES-1:0] timer_sync_q;
  logic [STAGES-1:0] soft_sync_q;

  logic        irq_ext_s;
  logic        irq_timer_s;
  logic        irq_soft_s;
  logic [31:0] mip_value;
  logic [31:0] pend;
  logic [3:0]  int_code;
  logic        take_int;
  logic        csr_we;
  logic [31:0] mstatus_value;
  logic [31:0] trap_base;
  logic [31:0] trap_vector;

  // Bring the asynchronous interrupt lines into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_sync_q   <= '0;
      timer_sync_q <= '0;
      soft_sync_q  <= '0;
    end else begin
      ext_sync_q   <= {ext_sync_q[STAGES-2:0], irq_ext_in};
      timer_sync_q <= {timer_sync_q[STAGES-2:0], irq_timer_in};
      soft_sync_q  <= {soft_sync_q[STAGES-2:0], irq_soft_in};
    end
  end

  assign irq_ext_s   = ext_sync_q[STAGES-1];
  assign irq_timer_s = timer_sync_q[STAGES-1];
  assign irq_soft_s  = soft_sync_q[STAGES-1];

  // Assemble mip from the synchronized lines at their architectural bits.
  always_comb begin
    mip_value     = '0;
    mip_value[3]  = irq_soft_s;
    mip_value[7]  = irq_timer_s;
    mip_value[11] = irq_ext_s;
  end

  assign pend = mip_value & mie_q;

  // Pick the highest-priority pending interrupt: ext, then soft, then timer.
  always_comb begin
    int_code = 4'd0;
    if (pend[11]) begin
      int_code = CODE_EXT;
    end else if (pend[3]) begin
      int_code = CODE_SOFT;
    end else if (pend[7]) begin
      int_code = CODE_TIMER;
    end
  end

  // Interrupts only slip in between instructions that do nothing else.
  assign take_int = (state_q == ST_IDLE) && mstatus_mie_q && (|pend) &&
                    int_allowed_in && !exc_valid_in && !mret_in && !csr_write_in;

  // A faulting instruction never gets to commit its CSR write.
  assign csr_we = (state_q == ST_IDLE) && csr_write_in && !exc_valid_in;

  // mstatus view: MPP is fixed at machine mode.
  always_comb begin
    mstatus_value        = '0;
    mstatus_value[3]     = mstatus_mie_q;
    mstatus_value[7]     = mstatus_mpie_q;
    mstatus_value[12:11] = 2'b11;
  end

  // Trap target: base, plus 4*code for interrupts when vectored mode is on.
  always_comb begin
    trap_base = {mtvec_q[31:2], 2'b00};
`ifdef RV32_TRAP_VECTORED_EN
    if (mtvec_q[0] && trap_cause_q[31]) begin
      trap_vector = trap_base + {26'b0, trap_cause_q[3:0], 2'b00};
    end else begin
      trap_vector = trap_base;
    end
`else
    trap_vector = trap_base;
`endif
  end

  // Combinational CSR read port; unowned addresses return zero with no hit.
  always_comb begin
    csr_rdata_out = '0;
    csr_hit_out   = 1'b0;
    case (csr_in)
      CSR_MSTATUS: begin csr_hit_out = 1'b1; csr_rdata_out = mstatus_value; end
      CSR_MIE:     begin csr_hit_out = 1'b1; csr_rdata_out = mie_q;         end
      CSR_MTVEC:   begin csr_hit_out = 1'b1; csr_rdata_out = mtvec_q;       end
      CSR_MEPC:    begin csr_hit_out = 1'b1; csr_rdata_out = mepc_q;        end
      CSR_MCAUSE:  begin csr_hit_out = 1'b1; csr_rdata_out = mcause_q;      end
      CSR_MTVAL:   begin csr_hit_out = 1'b1; csr_rdata_out = mtval_q;       end
      CSR_MIP:     begin csr_hit_out = 1'b1; csr_rdata_out = mip_value;     end
      default:     begin csr_hit_out = 1'b0; csr_rdata_out = '0;            end
    endcase
  end

  // Trap FSM plus CSR storage; FSM updates come after CSR writes so mret wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      stall_q        <= 1'b0;
      flush_q        <= 1'b0;
      redir_valid_q  <= 1'b0;
      redir_pc_q     <= '0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      trap_cause_q   <= '0;
      trap_pc_q      <= '0;
      trap_tval_q    <= '0;
    end else begin
      if (csr_we) begin
        case (csr_in)
          CSR_MSTATUS: begin
            mstatus_mie_q  <= csr_wdata_in[3];
            mstatus_mpie_q <= csr_wdata_in[7];
          end
          CSR_MIE:    mie_q    <= csr_wdata_in & MIE_MASK;
          CSR_MTVEC:  mtvec_q  <= csr_wdata_in & MTVEC_MASK;
          CSR_MEPC:   mepc_q   <= csr_wdata_in & MEPC_MASK;
          CSR_MCAUSE: mcause_q <= csr_wdata_in & MCAUSE_MASK;
          CSR_MTVAL:  mtval_q  <= csr_wdata_in;
          default: ;
        endcase
      end

      case (state_q)
        ST_IDLE: begin
          if (exc_valid_in) begin
            trap_cause_q <= {28'b0, exc_cause_in};
            trap_pc_q    <= exc_pc_in;
            trap_tval_q  <= exc_tval_in;
            state_q      <= ST_SAVE;
            stall_q      <= 1'b1;
          end else if (mret_in) begin
            redir_pc_q     <= mepc_q;
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
            flush_q        <= 1'b1;
            redir_valid_q  <= 1'b1;
            state_q        <= ST_REDIRECT;
            stall_q        <= 1'b1;
          end else if (take_int) begin
            trap_cause_q <= {1'b1, 27'b0, int_code};
            trap_pc_q    <= int_pc_in;
            trap_tval_q  <= '0;
            state_q      <= ST_SAVE;
            stall_q      <= 1'b1;
          end
        end

        ST_SAVE: begin
          mepc_q         <= trap_pc_q & MEPC_MASK;
          mcause_q       <= trap_cause_q & MCAUSE_MASK;
          mtval_q        <= trap_tval_q;
          mstatus_mpie_q <= mstatus_mie_q;
          mstatus_mie_q  <= 1'b0;
          redir_pc_q     <= trap_vector;
          flush_q        <= 1'b1;
          redir_valid_q  <= 1'b1;
          state_q        <= ST_REDIRECT;
          stall_q        <= 1'b1;
        end

        ST_REDIRECT: begin
          flush_q       <= 1'b0;
          redir_valid_q <= 1'b0;
          state_q       <= ST_IDLE;
          stall_q       <= 1'b0;
        end

        default: begin
          flush_q       <= 1'b0;
          redir_valid_q <= 1'b0;
          state_q       <= ST_IDLE;
          stall_q       <= 1'b0;
        end
      endcase
    end
  end

  assign stall_out          = stall_q;
  assign flush_out          = flush_q;
  assign redirect_valid_out = redir_valid_q;
  assign redirect_pc_out    = redir_pc_q;

endmodule

// File: doc/rv32_trap_ctrl.md
Name: rv32_trap_ctrl

Overview:
Machine-mode trap controller for the rv32 core. It owns the trap CSRs (mstatus, mie, mtvec, mepc, mcause, mtval, mip) and sequences trap entry and mret return. It arbitrates between synchronous exceptions, mret and three interrupt lines, then drives a flush and PC redirect into the pipeline. It sits beside the counter/ID CSR file: the execute stage presents CSR accesses to both, and each answers only for the addresses it owns.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the interrupt-line synchronizers (minimum 2)

Ports:
clk  input  1  core clock
reset_n  input  1  asynchronous, active-low reset
exc_valid_in  input  1  excepting instruction at writeback
exc_cause_in  input  4  exception code
exc_pc_in  input  32  PC of the faulting instruction
exc_tval_in  input  32  trap value
mret_in  input  1  mret at writeback
irq_ext_in  input  1  external interrupt, asynchronous
irq_timer_in  input  1  timer interrupt, asynchronous
irq_soft_in  input  1  software interrupt, asynchronous
int_allowed_in  input  1  pipeline is at an interruptible boundary
int_pc_in  input  32  PC of the oldest unretired instruction
csr_write_in  input  1  CSR write strobe (value already RW/RS/RC-resolved)
csr_in  input  12  CSR address
csr_wdata_in  input  32  CSR write value
csr_rdata_out  output  32  combinational read value
csr_hit_out  output  1  csr_in is owned by this block
stall_out  output  1  hold the pipeline
flush_out  output  1  kill all in-flight instructions
redirect_valid_out  output  1  fetch must jump
redirect_pc_out  output  32  jump target

Behaviour:
- Reset values (asynchronous, reset_n low):
  - state IDLE
  - MIE=0, MPIE=0; MPP is hardwired 2'b11 (read-only)
  - mie=0, mtvec=0, mepc=0, mcause=0, mtval=0
  - synchronizers cleared
  - stall_out, flush_out and redirect_valid_out are 0; redirect_pc_out is 0
- Reset asserted mid-trap drops redirect and flush immediately, with no partial CSR update.
- CSR map (all other addresses: csr_hit_out=0, rdata=0):
  - 0x300 mstatus: bit 3 MIE, bit 7 MPIE, bits 12:11 MPP; all other bits read 0.
  - 0x304 mie: bits 3, 7, 11 writable; others read 0.
  - 0x305 mtvec: base bits 31:2; mode bits 1:0 per the optional feature.
  - 0x341 mepc: bits 1:0 always read 0.
  - 0x342 mcause: bit 31 and bits 3:0 stored; others read 0.
  - 0x343 mtval: full 32 bits.
  - 0x344 mip: read-only; bit 3 = soft, bit 7 = timer, bit 11 = ext, taken from the synchronizer outputs; writes are ignored.
- CSR writes:
  - Commit on the next edge, only in IDLE, and only when exc_valid_in=0 (a faulting instruction's write is discarded).
  - Writes are ignored in SAVE and REDIRECT.
- Pending interrupts: pend = mip & mie.
  - take_int = IDLE & MIE & |pend & int_allowed_in & !exc_valid_in & !mret_in & !csr_write_in.
  - Interrupt priority: ext (code 11) > soft (3) > timer (7).
- FSM:
  - IDLE, priority exception > mret > interrupt:
    - exc_valid_in: latch {0, exc_cause_in}, exc_pc_in, exc_tval_in; go to SAVE.
    - mret_in: target = mepc; MIE<=MPIE; MPIE<=1; go to REDIRECT.
    - take_int: latch {1, code}, int_pc_in, tval=0; go to SAVE.
  - SAVE (1 cycle):
    - mepc<=pc (bits 1:0 cleared), mcause<=cause, mtval<=tval.
    - MPIE<=MIE; MIE<=0.
    - target <= trap vector; go to REDIRECT.
  - REDIRECT (1 cycle): flush_out=1, redirect_valid_out=1, redirect_pc_out=target; go to IDLE.
- stall_out = (state != IDLE).
- Latency:
  - Exception or interrupt accepted at edge N: redirect is visible during cycle N+2.
  - mret: redirect is visible during cycle N+1.
- exc_valid_in, mret_in and the irq lines are ignored outside IDLE; the irq lines stay visible in mip.
- An interrupt line deasserted before it is taken is simply not taken; nothing is latched.
- Trap vector: {mtvec[31:2], 2'b00}. In vectored mode, an interrupt adds 4*code (32-bit wrap). Exceptions always use the base.

Optional Feature:
RV32_TRAP_VECTORED_EN
- Defined: mtvec[0] is writable (mode 0 = direct, 1 = vectored); mtvec[1] reads 0; vectored interrupt targets as above.
- Undefined: mtvec[1:0] hardwired 0, and every trap targets the base.

Test Plan:
- Reset, then read 0x300 -> rdata 0x00001800, csr_hit_out=1. Read 0x344 with no IRQ -> 0. Read 0xC00 -> csr_hit_out=0.
- mtvec=0x00000100, MIE=1, exc_valid_in with cause 2, pc 0x80, tval 0xDEAD at cycle N -> redirect 0x100 and flush in cycle N+2 only. Afterwards mepc=0x80, mcause=0x2, mtval=0xDEAD, mstatus=0x1880.
- Following mret_in -> redirect 0x80 the next cycle; mstatus=0x1888.
- mie=0x888, MIE=1, irq_ext_in and irq_timer_in rise together, int_pc_in=0x200 -> mip bits set after SYNC_STAGES edges. Trap taken with mcause=0x8000000B, mepc=0x200. With RV32_TRAP_VECTORED_EN and mtvec=0x101, redirect=0x12C.
- exc_valid_in, mret_in and a pending enabled IRQ in the same cycle, plus csr_write_in to mscratch-range 0x340 -> exception wins, csr_hit_out=0, no write performed.
- Assert reset_n=0 during REDIRECT -> flush_out and redirect_valid_out fall without a clock edge. All CSRs return to reset values.
